// File: rtl/imem_controller.sv
// imem_controller: owns the single-port instruction array and arbitrates it
// between the host program-load port and the datapath fetch port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no program loaded, waiting for first host word or start
// S_LOAD | at least one word loaded, further words accepted
// S_RUN  | datapath fetches granted for addresses below the word count
// S_DONE | last word fetched; waiting for re-run or clear
module imem_controller #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_wr_valid,
    input  logic [DW-1:0] host_wr_data,
    output logic          host_wr_ready,
    input  logic          host_start,
    input  logic          host_clear,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [DW-1:0] fetch_rdata,
    output logic          mem_cen,
    output logic          mem_gwen,
    output logic [DW-1:0] mem_wen,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output logic [AW:0]   instruction_count,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [AW:0] count;
    logic [AW:0] count_after;
    logic        in_load;
    logic        wr_fire;
    logic        addr_ok;
    logic        overflow;
    logic        bad_fetch;
    logic        rvalid_q;
    logic        rlast_q;

    // Clear takes priority over every other host request, so it gates
    // acceptance of writes and grants of fetches in the same cycle.
    assign in_load       = (state == S_IDLE) || (state == S_LOAD);
    assign host_wr_ready = in_load && (count < DEPTH_C) && !host_clear;
    assign wr_fire       = host_wr_valid && host_wr_ready;
    assign addr_ok       = ({1'b0, fetch_addr} < count);
    assign fetch_gnt     = (state == S_RUN) && fetch_req && addr_ok && !host_clear;
    assign overflow      = in_load && host_wr_valid && (count == DEPTH_C) && !host_clear;
    assign bad_fetch     = (state == S_RUN) && fetch_req && !addr_ok && !host_clear;
    assign count_after   = wr_fire ? count + 1'b1 : count;

    assign fetch_rvalid      = rvalid_q;
    assign fetch_rdata       = mem_q;
    assign instruction_count = count;

    // Next-state decision; a write accepted alongside start counts toward
    // deciding whether there is anything to run.
    always_comb begin
        state_nxt = state;
        if (host_clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (host_start)
                        state_nxt = (count_after != '0) ? S_RUN : S_DONE;
                    else if (wr_fire)
                        state_nxt = S_LOAD;
                end
                S_RUN:   if (rvalid_q && rlast_q) state_nxt = S_DONE;
                S_DONE:  if (host_start) state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, count, sticky error, read-return pipeline and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            error    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
            rvalid_q <= fetch_gnt;
            rlast_q  <= fetch_gnt && ({1'b0, fetch_addr} == count - 1'b1);
            if (host_clear) begin
                count <= '0;
                error <= 1'b0;
            end else begin
                count <= count_after;
                if (overflow || bad_fetch)
                    error <= 1'b1;
            end
        end
    end

    // Array port mux: host write, datapath read, or parked idle values.
    always_comb begin
        mem_cen  = 1'b1;
        mem_gwen = 1'b1;
        mem_wen  = '1;
        mem_a    = '0;
        mem_d    = '0;
        if (wr_fire) begin
            mem_cen  = 1'b0;
            mem_gwen = 1'b0;
            mem_wen  = '0;
            mem_a    = count[AW-1:0];
            mem_d    = host_wr_data;
        end else if (fetch_gnt) begin
            mem_cen = 1'b0;
            mem_a   = fetch_addr;
        end
    end

endmodule

// File: doc/imem_controller.md
# imem_controller

Owns the single-port instruction array and shares it between the host program-load port and the datapath fetch port. Loads a program sequentially, tracks the instruction count, and sequences the IDLE/LOAD/RUN/DONE lifecycle. Sits between the host interface and the instruction array, ahead of the datapath's fetch stage.

## Interface
- DW, `FULL_INSTRUCTION_BITWIDTH: instruction word width
- AW, `IMEM_ADDR_WIDTH: array address width
- DEPTH, `IMEM_DEPTH: number of array words, DEPTH <= 2^AW
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- host_wr_valid  in  1  host offers one instruction word
- host_wr_data  in  DW  instruction word to load
- host_wr_ready  out  1  controller accepts host word this cycle
- host_start  in  1  begin program execution
- host_clear  in  1  discard program, return to IDLE
- fetch_req  in  1  datapath requests a fetch
- fetch_addr  in  AW  fetch address
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_rvalid  out  1  fetch_rdata valid; one cycle after grant
- fetch_rdata  out  DW  fetched word, driven from mem_q
- mem_cen  out  1  array chip enable, active-low
- mem_gwen  out  1  array global write enable, active-low
- mem_wen  out  DW  array bit write enables, active-low
- mem_a  out  AW  array address
- mem_d  out  DW  array write data
- mem_q  in  DW  array read data, one cycle after address
- instruction_count  out  AW+1  words loaded, 0..DEPTH
- busy  out  1  state is RUN
- done  out  1  state is DONE
- error  out  1  sticky: load overflow or out-of-range fetch

## Operation
- States: IDLE, LOAD, RUN, DONE; reset to IDLE.
- IDLE/LOAD write: host_wr_ready = (count < DEPTH). On valid&ready: mem_cen=0, mem_gwen=0, mem_wen=all 0, mem_a=count[AW-1:0], mem_d=host_wr_data; count increments next edge. First accepted write moves IDLE->LOAD.
- Overflow: host_wr_valid while count == DEPTH -> no write, count unchanged, error set.
- host_start in IDLE/LOAD: count > 0 -> RUN; count == 0 -> DONE. A write accepted in the same cycle as host_start completes and is counted.
- RUN: host_wr_ready = 0. fetch_gnt = fetch_req & (fetch_addr < count). On grant: mem_cen=0, mem_gwen=1, mem_wen=all 1, mem_a=fetch_addr. fetch_req with fetch_addr >= count: no grant, no array access, error set.
- RUN->DONE on the cycle fetch_rvalid returns the word at address count-1. Any in-flight read completes, with fetch_rvalid asserted, before DONE takes effect.
- DONE: no grants, no writes. host_start -> RUN (re-run without reload). host_clear -> IDLE.
- host_clear in any state: next state IDLE, count=0, error=0. host_clear beats host_start and host_wr_valid in the same cycle; a write in that cycle is not performed.
- When no access: mem_cen=1, mem_gwen=1, mem_wen=all 1, mem_a=0, mem_d=0.

## Timing
- Reset values: state IDLE, count 0, host_wr_ready 1, fetch_gnt 0, fetch_rvalid 0, busy 0, done 0, error 0, mem_cen 1, mem_gwen 1, mem_wen all 1, mem_a 0, mem_d 0.
- Write latency: the word is in the array and count is updated at the edge ending the accept cycle.
- Fetch latency: grant in cycle N, fetch_rvalid=1 and fetch_rdata valid in cycle N+1. Back-to-back grants give one word per cycle.
- busy and done are registered from state; RUN entry is visible the cycle after host_start.
- Reset asserted mid-RUN: all outputs return to reset values immediately. Any pending fetch_rvalid is dropped.

## Test plan
- Load 3 words (0xA, 0xB, 0xC) -> writes at addresses 0,1,2; count=3; state LOAD.
- host_start, then fetch addresses 0,1,2 on consecutive cycles -> grants each cycle; rvalid data 0xA, 0xB, 0xC one cycle later; done=1 the cycle after the third rvalid.
- Fill DEPTH words, then one more write -> host_wr_ready=0, count=DEPTH, error=1.
- In RUN, fetch_addr=count -> fetch_gnt=0, mem_cen=1, error=1.
- host_start with count=0 -> done=1, no grants. host_clear together with host_start in DONE -> IDLE, count=0.
- Assert rst_n low the cycle after a fetch grant -> fetch_rvalid=0, busy=0, count=0.
